// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmit state encoding, clock filter
// hysteresis thresholds and the frame parity helper. Used by both the host
// transmitter and the receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    // Integrator thresholds: filtered level drops at 4 and rises at 11.
    localparam logic [3:0] FILT_LOW_THR  = 4'd4;
    localparam logic [3:0] FILT_HIGH_THR = 4'd11;

    // PS/2 frames carry odd parity over the 8 data bits.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Two-flop synchronizer for the raw PS/2 clock and data pads, plus a
// saturating 4-bit integrator with hysteresis that turns the noisy PS/2
// clock into a clean level and single-cycle edge strobes.
module ps2_clk_filter
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_level,
    output logic data_sync,
    output logic fall_edge,
    output logic any_edge
);

    logic       clk_meta;
    logic       clk_sync;
    logic       data_meta;
    logic [3:0] integ;
    logic       level_prev;

    // Synchronize both pads, integrate the clock, apply hysteresis.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta   <= 1'b1;
            clk_sync   <= 1'b1;
            data_meta  <= 1'b1;
            data_sync  <= 1'b1;
            integ      <= 4'hF;
            clk_level  <= 1'b1;
            level_prev <= 1'b1;
        end else begin
            clk_meta   <= ps2_clk;
            clk_sync   <= clk_meta;
            data_meta  <= ps2_data;
            data_sync  <= data_meta;
            level_prev <= clk_level;
            if (clk_sync && integ != 4'hF)
                integ <= integ + 4'd1;
            else if (!clk_sync && integ != 4'h0)
                integ <= integ - 4'd1;
            if (integ == FILT_LOW_THR)
                clk_level <= 1'b0;
            else if (integ == FILT_HIGH_THR)
                clk_level <= 1'b1;
        end
    end

    assign fall_edge = level_prev & ~clk_level;
    assign any_edge  = level_prev ^ clk_level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter. Inhibits the bus, issues the
// request-to-send start bit, shifts out data/parity/stop on device clock
// falling edges, samples the device ack and waits for the bus to go idle.
// Optional feature macro PS2_TX_ACK_CHECK_EN: a NACK (ack bit 1) ends the
// transfer with tx_err instead of tx_done.
//
// state     | meaning
// IDLE      | bus released, waiting for tx_start
// INHIBIT   | holding ps2 clock low; data pulled low in the final cycle
// SEND      | clock released, shifting bits out on falling edges 1..10
// ACK       | waiting for falling edge 11 to sample the device ack
// WAIT_IDLE | waiting for clock and data both high before reporting
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_ONE  = INH_W'(1);
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic             INH_SINGLE = (INHIBIT_CYCLES == 1);

    ps2_state_e       state;
    logic [9:0]       frame;
    logic [3:0]       bit_cnt;
    logic [INH_W-1:0] inh_cnt;
    logic [TO_W-1:0]  to_cnt;
`ifdef PS2_TX_ACK_CHECK_EN
    logic             ack_q;
`endif

    logic filt_level;
    logic filt_data;
    logic filt_fall;
    logic filt_any;
    logic timed_out;

    ps2_clk_filter u_clk_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .clk_level (filt_level),
        .data_sync (filt_data),
        .fall_edge (filt_fall),
        .any_edge  (filt_any)
    );

    // Timer expires when it has counted down to zero with no edge this cycle.
    assign timed_out = (to_cnt == '0) && !filt_any;

    // Transmit sequencer with registered line enables and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            frame       <= '0;
            bit_cnt     <= '0;
            inh_cnt     <= '0;
            to_cnt      <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
            ack_q       <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        // Stop bit, parity, then data LSB first.
                        frame       <= {1'b1, odd_parity(tx_data), tx_data};
                        bit_cnt     <= '0;
                        inh_cnt     <= INH_LOAD;
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= INH_SINGLE;
                        tx_busy     <= 1'b1;
                        state       <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt == '0) begin
                        // Data stays low: that is the start bit.
                        ps2_clk_oe <= 1'b0;
                        to_cnt     <= TO_LOAD;
                        state      <= SEND;
                    end else begin
                        inh_cnt <= inh_cnt - INH_ONE;
                        if (inh_cnt == INH_ONE)
                            ps2_data_oe <= 1'b1;
                    end
                end
                SEND, ACK, WAIT_IDLE: begin
                    if (filt_any)
                        to_cnt <= TO_LOAD;
                    else if (to_cnt != '0)
                        to_cnt <= to_cnt - TO_W'(1);

                    if (timed_out) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_busy     <= 1'b0;
                        tx_err      <= 1'b1;
                        state       <= IDLE;
                    end else if (state == SEND) begin
                        if (filt_fall) begin
                            ps2_data_oe <= ~frame[0];
                            frame       <= {1'b0, frame[9:1]};
                            bit_cnt     <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd9)
                                state <= ACK;
                        end
                    end else if (state == ACK) begin
                        if (filt_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
                            ack_q <= filt_data;
`endif
                            state <= WAIT_IDLE;
                        end
                    end else begin
                        if (filt_level && filt_data) begin
`ifdef PS2_TX_ACK_CHECK_EN
                            if (ack_q)
                                tx_err <= 1'b1;
                            else
                                tx_done <= 1'b1;
`else
                            tx_done <= 1'b1;
`endif
                            tx_busy <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    tx_busy     <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple open-drain PS/2 device model.
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int TO  = 400;
    localparam int H   = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic clk_echo = 1'b1;

    int n_total = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int err_cyc = 0;
    logic [1:0] err_oe = 2'b00;

    // Wired-AND pads; clk_echo=0 isolates the clock pin from the host driver.
    assign ps2_clk  = dev_clk & ~(clk_echo & ps2_clk_oe);
    assign ps2_data = dev_data & ~ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_err) begin
            err_cnt++;
            err_cyc = cyc;
            err_oe  = {ps2_clk_oe, ps2_data_oe};
        end
        if (tx_done && tx_err) both_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Starts a transfer of d, measures the inhibit phase, then clocks n_pulses.
    task automatic device_frame(input logic [7:0] d, input int n_pulses, input logic ack_bit,
                                output logic [9:0] rx, output int inh_len, output int inh_doe,
                                output logic doe_last, output int send_cyc);
        int guard;
        rx = '0; inh_len = 0; inh_doe = 0; doe_last = 1'b0; guard = 0;
        @(negedge clk);
        tx_data = d;
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        check_val("busy_after_start", 32'(tx_busy), 32'd1);
        while (ps2_clk_oe && guard < 5000) begin
            inh_len++;
            if (ps2_data_oe) inh_doe++;
            doe_last = ps2_data_oe;
            @(posedge clk); #1;
            guard++;
        end
        send_cyc = cyc;
        repeat (H) @(negedge clk);
        for (int i = 1; i <= n_pulses; i++) begin
            if (i == 11) begin
                dev_data = ack_bit;
                repeat (H / 2) @(negedge clk);
            end
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            if (i <= 10) rx[i-1] = ps2_data;
            repeat (H) @(negedge clk);
            if (i == 11) dev_data = 1'b1;
        end
    endtask

    task automatic wait_result(input int d0, input int e0);
        int guard;
        guard = 0;
        while (done_cnt == d0 && err_cnt == e0 && guard < 2 * TO) begin
            @(negedge clk);
            guard++;
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        logic [9:0] rx;
        int inh_len, inh_doe, send_cyc, d0, e0;
        logic doe_last;

        repeat (4) @(posedge clk);
        #1;
        check_val("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check_val("rst_status", 32'({tx_busy, tx_done, tx_err}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // 0xED, ack 0
        d0 = done_cnt; e0 = err_cnt;
        device_frame(8'hED, 11, 1'b0, rx, inh_len, inh_doe, doe_last, send_cyc);
        wait_result(d0, e0);
        check_val("ed_data", 32'(rx[7:0]), 32'hED);
        check_val("ed_parity", 32'(rx[8]), 32'd1);
        check_val("ed_stop", 32'(rx[9]), 32'd1);
        check_val("ed_done", 32'(done_cnt - d0), 32'd1);
        check_val("ed_err", 32'(err_cnt - e0), 32'd0);
        check_val("ed_busy_end", 32'(tx_busy), 32'd0);
        repeat (50) @(negedge clk);

        // 0x00: parity and inhibit timing
        d0 = done_cnt; e0 = err_cnt;
        device_frame(8'h00, 11, 1'b0, rx, inh_len, inh_doe, doe_last, send_cyc);
        wait_result(d0, e0);
        check_val("z_data", 32'(rx[7:0]), 32'h00);
        check_val("z_parity", 32'(rx[8]), 32'd1);
        check_val("z_inh_len", 32'(inh_len), 32'(INH));
        check_val("z_inh_doe_cnt", 32'(inh_doe), 32'd1);
        check_val("z_inh_doe_last", 32'(doe_last), 32'd1);
        check_val("z_done", 32'(done_cnt - d0), 32'd1);
        repeat (50) @(negedge clk);

        // device never clocks: timeout
        clk_echo = 1'b0;
        d0 = done_cnt; e0 = err_cnt;
        device_frame(8'h3C, 0, 1'b0, rx, inh_len, inh_doe, doe_last, send_cyc);
        wait_result(d0, e0);
        check_val("to_err", 32'(err_cnt - e0), 32'd1);
        check_val("to_done", 32'(done_cnt - d0), 32'd0);
        check_val("to_delay", 32'(err_cyc - send_cyc), 32'(TO));
        check_val("to_oe", 32'(err_oe), 32'd0);
        check_val("to_busy", 32'(tx_busy), 32'd0);
        clk_echo = 1'b1;
        repeat (50) @(negedge clk);

        // ack 1 (NACK)
        d0 = done_cnt; e0 = err_cnt;
        device_frame(8'h01, 11, 1'b1, rx, inh_len, inh_doe, doe_last, send_cyc);
        wait_result(d0, e0);
        check_val("nack_data", 32'(rx[7:0]), 32'h01);
        check_val("nack_parity", 32'(rx[8]), 32'd0);
`ifdef PS2_TX_ACK_CHECK_EN
        check_val("nack_err", 32'(err_cnt - e0), 32'd1);
        check_val("nack_done", 32'(done_cnt - d0), 32'd0);
`else
        check_val("nack_err", 32'(err_cnt - e0), 32'd0);
        check_val("nack_done", 32'(done_cnt - d0), 32'd1);
`endif
        repeat (50) @(negedge clk);

        // 0xF4 with 0xFF restarts during the transfer
        d0 = done_cnt; e0 = err_cnt;
        fork
            device_frame(8'hF4, 11, 1'b0, rx, inh_len, inh_doe, doe_last, send_cyc);
            begin
                repeat (20) @(negedge clk);
                tx_data = 8'hFF; tx_start = 1'b1;
                @(negedge clk); tx_start = 1'b0;
                repeat (300) @(negedge clk);
                tx_start = 1'b1;
                @(negedge clk); tx_start = 1'b0;
            end
        join
        wait_result(d0, e0);
        check_val("f4_data", 32'(rx[7:0]), 32'hF4);
        check_val("f4_parity", 32'(rx[8]), 32'd0);
        check_val("f4_stop", 32'(rx[9]), 32'd1);
        check_val("f4_done", 32'(done_cnt - d0), 32'd1);
        repeat (50) @(negedge clk);

        // reset after edge 5
        d0 = done_cnt; e0 = err_cnt;
        device_frame(8'hF4, 5, 1'b0, rx, inh_len, inh_doe, doe_last, send_cyc);
        check_val("mid_busy", 32'(tx_busy), 32'd1);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check_val("mid_rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check_val("mid_rst_busy", 32'(tx_busy), 32'd0);
        @(negedge clk); reset = 1'b0;
        repeat (2 * TO) @(negedge clk);
        check_val("mid_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);

        d0 = done_cnt; e0 = err_cnt;
        device_frame(8'hAA, 11, 1'b0, rx, inh_len, inh_doe, doe_last, send_cyc);
        wait_result(d0, e0);
        check_val("post_data", 32'(rx[7:0]), 32'hAA);
        check_val("post_parity", 32'(rx[8]), 32'd1);
        check_val("post_done", 32'(done_cnt - d0), 32'd1);
        check_val("post_err", 32'(err_cnt - e0), 32'd0);

        check_val("done_err_overlap", 32'(both_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
